regfile_wb_arbiter: RTL and testbench



---
 rtl/regfile_wb_arbiter_pkg.sv | 14 +
 rtl/regfile_wb_arbiter_if.sv | 34 +++
 rtl/regfile_wb_arbiter_wb_fifo.sv | 67 ++++++
 rtl/regfile_wb_arbiter.sv | 130 +++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter.
package regfile_pkg;

  localparam int RF_ADDR_W   = 5;
  localparam int RF_DATA_W   = 32;
  localparam int RF_NUM_REGS = 1 << RF_ADDR_W;

  // One writeback request: destination register and result.
  typedef struct packed {
    logic [RF_ADDR_W-1:0] addr;
    logic [RF_DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus: ALU and long-latency request channels, register-file
// write port, and the interlock/status outputs.
interface regfile_wb_arbiter_if
  import regfile_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W,
  parameter int DATA_W = RF_DATA_W
);
  logic                     alu_valid;
  logic                     alu_ready;
  logic [ADDR_W-1:0]        alu_waddr;
  logic [DATA_W-1:0]        alu_wdata;
  logic                     lu_valid;
  logic                     lu_ready;
  logic [ADDR_W-1:0]        lu_waddr;
  logic [DATA_W-1:0]        lu_wdata;
  logic                     rf_wen;
  logic [ADDR_W-1:0]        rf_waddr;
  logic [DATA_W-1:0]        rf_wdata;
  logic [(1<<ADDR_W)-1:0]   pending;
  logic                     waw_err;

  // Request side (pipeline / testbench).
  modport master (
    output alu_valid, alu_waddr, alu_wdata, lu_valid, lu_waddr, lu_wdata,
    input  alu_ready, lu_ready, rf_wen, rf_waddr, rf_wdata, pending, waw_err
  );

  // Arbiter side.
  modport slave (
    input  alu_valid, alu_waddr, alu_wdata, lu_valid, lu_waddr, lu_wdata,
    output alu_ready, lu_ready, rf_wen, rf_waddr, rf_wdata, pending, waw_err
  );
endinterface

// File: rtl/regfile_wb_arbiter_wb_fifo.sv
// Small synchronous FIFO for long-latency results. Entries are {addr, data};
// per-slot valid and address taps let the parent build the pending vector.
module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 37,
  parameter int AW    = 5,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [CNT_W-1:0]         count,
  output logic [DEPTH-1:0]         entry_valid,
  output logic [DEPTH-1:0][AW-1:0] entry_addr
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] ent_off [DEPTH];

  assign head  = mem[rd_ptr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // Pointer and occupancy bookkeeping; depth is a power of two so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage write.
  // NOTE: the data array is deliberately not reset; occupancy alone decides which slots are meaningful.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // A slot is live when its distance from the read pointer is below the count.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
    entry_valid = '0;
    entry_addr  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ent_off[i]     = PTR_W'(i) - rd_ptr;
      entry_valid[i] = ({1'b0, ent_off[i]} < count);
      entry_addr[i]  = mem[i][WIDTH-1 -: AW];
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file's single write port between the in-order ALU
// writeback and buffered long-latency results, with a starvation guard and a
// per-register pending vector for issue interlocks.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_W       = RF_DATA_W,
  parameter int ADDR_W       = RF_ADDR_W,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_wb_arbiter_if.slave  bus
);

  localparam int NUM_REGS = 1 << ADDR_W;
  localparam int ENTRY_W  = ADDR_W + DATA_W;
  localparam int SC_W     = $clog2(STARVE_LIMIT + 1);
  localparam int CNT_W    = $clog2(FIFO_DEPTH) + 1;

  logic [ENTRY_W-1:0]               head;
  logic [ADDR_W-1:0]                head_addr;
  logic [DATA_W-1:0]                head_data;
  logic                             fifo_full;
  logic                             fifo_empty;
  logic [CNT_W-1:0]                 fifo_count;
  logic [FIFO_DEPTH-1:0]            ent_valid;
  logic [FIFO_DEPTH-1:0][ADDR_W-1:0] ent_addr;

  logic              alu_acc;
  logic              lu_push;
  logic              fifo_pop;
  logic              starve_hit;
  logic [SC_W-1:0]   starve_cnt;
  logic              rf_wen_q;
  logic [ADDR_W-1:0] rf_waddr_q;
  logic [DATA_W-1:0] rf_wdata_q;
  logic              out_is_lu_q;
  logic              waw_err_q;
  logic [NUM_REGS-1:0] pending_c;

  assign {head_addr, head_data} = head;

  // At the starvation limit the ALU is held off so the FIFO head drains.
  assign starve_hit    = (starve_cnt == SC_W'(STARVE_LIMIT)) && (fifo_count != '0);
  assign bus.alu_ready = !starve_hit;
  assign bus.lu_ready  = !fifo_full;
  assign alu_acc       = bus.alu_valid && bus.alu_ready;
  assign lu_push       = bus.lu_valid && bus.lu_ready;
  // ALU wins the port; the FIFO head drains only on ALU-idle cycles.
  assign fifo_pop      = !alu_acc && !fifo_empty;

  wb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W),
    .AW    (ADDR_W)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (lu_push),
    .push_data   ({bus.lu_waddr, bus.lu_wdata}),
    .pop         (fifo_pop),
    .head        (head),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .count       (fifo_count),
    .entry_valid (ent_valid),
    .entry_addr  (ent_addr)
  );

  // Registered write port: the granted request appears one cycle after grant.
  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      rf_wen_q    <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
      out_is_lu_q <= 1'b0;
    end else if (alu_acc) begin
      rf_wen_q    <= (bus.alu_waddr != '0);
      rf_waddr_q  <= bus.alu_waddr;
      rf_wdata_q  <= bus.alu_wdata;
      out_is_lu_q <= 1'b0;
    end else if (fifo_pop) begin
      rf_wen_q    <= (head_addr != '0);
      rf_waddr_q  <= head_addr;
      rf_wdata_q  <= head_data;
      out_is_lu_q <= 1'b1;
    end else begin
      rf_wen_q    <= 1'b0;
      out_is_lu_q <= 1'b0;
    end
  end

  // Starvation counter: counts cycles a non-empty FIFO goes without a pop.
  always_ff @(posedge clk) begin
    if (rst || fifo_empty || fifo_pop) begin
      starve_cnt <= '0;
    end else if (starve_cnt != SC_W'(STARVE_LIMIT)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Pending: any live FIFO entry, plus a long-latency write sitting in the output stage.
  always_comb begin
    pending_c = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (ent_valid[i]) pending_c[ent_addr[i]] = 1'b1;
    end
    if (rf_wen_q && out_is_lu_q) pending_c[rf_waddr_q] = 1'b1;
    pending_c[0] = 1'b0;
  end

  // Sticky write-after-write hazard flag: ALU overtaking a buffered result.
  always_ff @(posedge clk) begin
    if (rst) begin
      waw_err_q <= 1'b0;
    end else if (alu_acc && (bus.alu_waddr != '0) && pending_c[bus.alu_waddr]) begin
      waw_err_q <= 1'b1;
    end
  end

  assign bus.rf_wen   = rf_wen_q;
  assign bus.rf_waddr = rf_waddr_q;
  assign bus.rf_wdata = rf_wdata_q;
  assign bus.pending  = pending_c;
  assign bus.waw_err  = waw_err_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: table-driven ALU writes plus
// hand-written starvation, FIFO-fill, WAW and mid-operation reset sequences.
// Every register-file write is matched against a scoreboard queue.
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if bus ();

  regfile_wb_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  wb_req_t exp_q[$];

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    logic        exp_wen;
  } alu_vec_t;

  alu_vec_t vecs[6];
  logic     exp_rdy[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.alu_valid = 1'b0;
    bus.alu_waddr = '0;
    bus.alu_wdata = '0;
    bus.lu_valid  = 1'b0;
    bus.lu_waddr  = '0;
    bus.lu_wdata  = '0;
  endtask

  task automatic expect_write(input logic [4:0] a, input logic [31:0] d);
    wb_req_t r;
    r.addr = a;
    r.data = d;
    exp_q.push_back(r);
  endtask

  task automatic drive_alu(input logic [4:0] a, input logic [31:0] d);
    bus.alu_valid = 1'b1;
    bus.alu_waddr = a;
    bus.alu_wdata = d;
  endtask

  task automatic drive_lu(input logic [4:0] a, input logic [31:0] d);
    bus.lu_valid = 1'b1;
    bus.lu_waddr = a;
    bus.lu_wdata = d;
  endtask

  // Scoreboard: every visible write must match the oldest expected write.
  always @(negedge clk) begin : sb_monitor
    wb_req_t e;
    if (bus.rf_wen === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("sb_spurious_wen", bus.rf_wen, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check("sb_waddr", bus.rf_waddr, e.addr);
        check("sb_wdata", bus.rf_wdata, e.data);
      end
    end
  end

  initial begin
    int j;
    vecs[0] = '{5'd5,  32'hDEAD_BEEF, 1'b1};
    vecs[1] = '{5'd0,  32'h1234_5678, 1'b0};
    vecs[2] = '{5'd31, 32'hFFFF_FFFF, 1'b1};
    vecs[3] = '{5'd1,  32'h0000_0000, 1'b1};
    vecs[4] = '{5'd0,  32'hCAFE_F00D, 1'b0};
    vecs[5] = '{5'd18, 32'hA5A5_A5A5, 1'b1};
    exp_rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    // Reset then idle.
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("rst_rf_wen",    bus.rf_wen,    1'b0);
    check("rst_rf_waddr",  bus.rf_waddr,  '0);
    check("rst_rf_wdata",  bus.rf_wdata,  '0);
    check("rst_pending",   bus.pending,   '0);
    check("rst_alu_ready", bus.alu_ready, 1'b1);
    check("rst_lu_ready",  bus.lu_ready,  1'b1);
    check("rst_waw_err",   bus.waw_err,   1'b0);

    // ALU-only writes: visible for exactly one cycle, register 0 suppressed.
    foreach (vecs[i]) begin
      drive_alu(vecs[i].addr, vecs[i].data);
      check("alu_ready", bus.alu_ready, 1'b1);
      if (vecs[i].exp_wen) expect_write(vecs[i].addr, vecs[i].data);
      tick();
      check("alu_wen", bus.rf_wen, vecs[i].exp_wen);
      idle_inputs();
      tick();
      check("alu_wen_one_cycle", bus.rf_wen, 1'b0);
      if (vecs[i].exp_wen) check("alu_waddr_hold", bus.rf_waddr, vecs[i].addr);
    end

    // Starvation: ALU busy every cycle, one long-latency result to r7.
    j = 0;
    drive_alu(5'd2, 32'h100);
    drive_lu(5'd7, 32'h11);
    for (int i = 0; i < 7; i++) begin
      bus.alu_wdata = 32'h100 + j;
      check("starve_alu_ready", bus.alu_ready, exp_rdy[i]);
      if (exp_rdy[i]) begin
        expect_write(5'd2, 32'h100 + j);
        j++;
      end else begin
        expect_write(5'd7, 32'h11);
      end
      tick();
      bus.lu_valid = 1'b0;
      if (i == 0) check("starve_pend7_set", bus.pending[7], 1'b1);
      if (i == 5) check("starve_pend7_outstage", bus.pending[7], 1'b1);
      if (i == 6) check("starve_pend7_clear", bus.pending[7], 1'b0);
    end
    idle_inputs();
    tick();

    // FIFO fill: two results to r3 while the ALU holds the port, then drain in order.
    drive_alu(5'd4, 32'h40);
    drive_lu(5'd3, 32'hA);
    expect_write(5'd4, 32'h40);
    tick();
    drive_alu(5'd4, 32'h41);
    drive_lu(5'd3, 32'hB);
    check("fill_lu_ready_one", bus.lu_ready, 1'b1);
    expect_write(5'd4, 32'h41);
    tick();
    check("fill_lu_ready_full", bus.lu_ready, 1'b0);
    check("fill_pend3", bus.pending[3], 1'b1);
    idle_inputs();
    drive_lu(5'd6, 32'h66);
    expect_write(5'd3, 32'hA);
    tick();
    bus.lu_valid = 1'b0;
    check("fill_pend3_after_a", bus.pending[3], 1'b1);
    check("fill_lu_ready_after_pop", bus.lu_ready, 1'b1);
    expect_write(5'd3, 32'hB);
    tick();
    check("fill_pend3_b_outstage", bus.pending[3], 1'b1);
    tick();
    check("fill_pend3_clear", bus.pending[3], 1'b0);
    check("fill_pend6_refused", bus.pending[6], 1'b0);

    // WAW: ALU writes r9 while a long-latency r9 result is buffered.
    drive_alu(5'd4, 32'h50);
    drive_lu(5'd9, 32'h99);
    expect_write(5'd4, 32'h50);
    tick();
    check("waw_before", bus.waw_err, 1'b0);
    check("waw_pend9", bus.pending[9], 1'b1);
    bus.lu_valid = 1'b0;
    drive_alu(5'd9, 32'h77);
    expect_write(5'd9, 32'h77);
    tick();
    check("waw_set", bus.waw_err, 1'b1);
    idle_inputs();
    expect_write(5'd9, 32'h99);
    tick();
    tick();
    tick();
    check("waw_sticky", bus.waw_err, 1'b1);

    // Fill the FIFO, then reset mid-operation: buffered entries must vanish.
    drive_alu(5'd4, 32'h60);
    drive_lu(5'd10, 32'hAA);
    expect_write(5'd4, 32'h60);
    tick();
    drive_alu(5'd4, 32'h61);
    drive_lu(5'd11, 32'hBB);
    expect_write(5'd4, 32'h61);
    tick();
    check("mrst_full", bus.lu_ready, 1'b0);
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_rf_wen",    bus.rf_wen,    1'b0);
    check("mrst_pending",   bus.pending,   '0);
    check("mrst_lu_ready",  bus.lu_ready,  1'b1);
    check("mrst_alu_ready", bus.alu_ready, 1'b1);
    check("mrst_waw_clear", bus.waw_err,   1'b0);
    repeat (4) tick();
    check("mrst_no_stale", bus.rf_wen, 1'b0);
    check("sb_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
